// File: rtl/video_mode_pkg.sv
// Shared definitions for the video timing controller: mode ids, per-mode
// timing constants and the controller state encoding.
package video_mode_pkg;

    localparam int TIMING_W = 12;

    localparam logic [1:0] MODE_1080P   = 2'd0;
    localparam logic [1:0] MODE_720P    = 2'd1;
    localparam logic [1:0] MODE_480P    = 2'd2;
    localparam logic [1:0] MODE_800X600 = 2'd3;

    typedef struct packed {
        logic [TIMING_W-1:0] h_total;
        logic [TIMING_W-1:0] h_fp;
        logic [TIMING_W-1:0] h_bp;
        logic [TIMING_W-1:0] h_sync;
        logic [TIMING_W-1:0] h_act;
        logic [TIMING_W-1:0] v_total;
        logic [TIMING_W-1:0] v_fp;
        logic [TIMING_W-1:0] v_bp;
        logic [TIMING_W-1:0] v_sync;
        logic [TIMING_W-1:0] v_act;
    } mode_timing_t;

    localparam mode_timing_t TIMING_1080P = '{
        h_total: 12'd2200, h_fp: 12'd88, h_bp: 12'd148, h_sync: 12'd44, h_act: 12'd1920,
        v_total: 12'd1125, v_fp: 12'd4, v_bp: 12'd36, v_sync: 12'd5, v_act: 12'd1080};

    localparam mode_timing_t TIMING_720P = '{
        h_total: 12'd1650, h_fp: 12'd110, h_bp: 12'd220, h_sync: 12'd40, h_act: 12'd1280,
        v_total: 12'd750, v_fp: 12'd5, v_bp: 12'd20, v_sync: 12'd5, v_act: 12'd720};

    localparam mode_timing_t TIMING_480P = '{
        h_total: 12'd858, h_fp: 12'd16, h_bp: 12'd60, h_sync: 12'd62, h_act: 12'd720,
        v_total: 12'd525, v_fp: 12'd9, v_bp: 12'd30, v_sync: 12'd6, v_act: 12'd480};

    localparam mode_timing_t TIMING_800X600 = '{
        h_total: 12'd1056, h_fp: 12'd40, h_bp: 12'd88, h_sync: 12'd128, h_act: 12'd800,
        v_total: 12'd628, v_fp: 12'd1, v_bp: 12'd23, v_sync: 12'd4, v_act: 12'd600};

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WAIT_VS = 2'd2,
        ST_HOLD    = 2'd3
    } vtc_state_e;

    function automatic mode_timing_t mode_lookup(input logic [1:0] mode_id);
        mode_timing_t t;
        t = TIMING_1080P;
        case (mode_id)
            MODE_1080P:   t = TIMING_1080P;
            MODE_720P:    t = TIMING_720P;
            MODE_480P:    t = TIMING_480P;
            MODE_800X600: t = TIMING_800X600;
            default:      t = TIMING_1080P;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/video_mode_rom.sv
// Combinational mode table: 2-bit mode id to the ten timing fields.
module video_mode_rom
    import video_mode_pkg::*;
(
    input  logic [1:0]   mode_id,
    output mode_timing_t timing
);

    always_comb begin
        timing = mode_lookup(mode_id);
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Runtime mode controller: accepts mode requests, waits for a frame boundary
// and restarts the timing generator with the new mode's timing.
module video_timing_ctrl
    import video_mode_pkg::*;
#(
    parameter int         X_BITS       = 12,
    parameter int         Y_BITS       = 12,
    parameter logic [1:0] DEFAULT_MODE = 2'd0,
    parameter int         RST_HOLD     = 16,
    parameter int         TIMEOUT      = 4194304,
    parameter int         TO_BITS      = 23
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    input  logic [1:0]        req_mode,
    output logic              req_ready,
    input  logic              vs_in,
    output logic              gen_rstn,
    output logic [X_BITS-1:0] h_total,
    output logic [X_BITS-1:0] h_fp,
    output logic [X_BITS-1:0] h_bp,
    output logic [X_BITS-1:0] h_sync,
    output logic [X_BITS-1:0] h_act,
    output logic [Y_BITS-1:0] v_total,
    output logic [Y_BITS-1:0] v_fp,
    output logic [Y_BITS-1:0] v_bp,
    output logic [Y_BITS-1:0] v_sync,
    output logic [Y_BITS-1:0] v_act,
    output logic [1:0]        cur_mode,
    output logic              busy,
    output logic              mode_done,
    output logic              timeout_err,
    output logic [15:0]       frame_cnt
);

    localparam int                 HC_BITS       = (RST_HOLD > 2) ? $clog2(RST_HOLD) : 1;
    localparam logic [HC_BITS-1:0] HOLD_LAST     = HC_BITS'(RST_HOLD - 1);
    localparam logic [TO_BITS-1:0] TO_LAST       = TO_BITS'(TIMEOUT - 1);
    localparam mode_timing_t       RESET_TIMING  = mode_lookup(DEFAULT_MODE);

    vtc_state_e         state_q, state_d;
    logic [HC_BITS-1:0] hold_cnt_q, hold_cnt_d;
    logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]         pend_mode_q, pend_mode_d;
    logic [1:0]         cur_mode_q, cur_mode_d;
    mode_timing_t       timing_q, timing_d;
    logic               gen_rstn_q, gen_rstn_d;
    logic               mode_done_q, mode_done_d;
    logic               timeout_err_q, timeout_err_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               vs_dly_q, vs_dly_d;
    logic               vs_rise;
    mode_timing_t       rom_timing;

    video_mode_rom u_rom (
        .mode_id (pend_mode_q),
        .timing  (rom_timing)
    );

    assign vs_rise = vs_in & ~vs_dly_q;

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        to_cnt_d      = to_cnt_q;
        pend_mode_d   = pend_mode_q;
        cur_mode_d    = cur_mode_q;
        timing_d      = timing_q;
        gen_rstn_d    = gen_rstn_q;
        mode_done_d   = 1'b0;
        timeout_err_d = timeout_err_q;
        frame_cnt_d   = frame_cnt_q;
        vs_dly_d      = vs_in;

        if (vs_rise && (state_q == ST_RUN || state_q == ST_WAIT_VS)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        case (state_q)
            ST_INIT: begin
                gen_rstn_d = 1'b0;
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    gen_rstn_d = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (req_valid) begin
                    timeout_err_d = 1'b0;
                    if (req_mode == cur_mode_q) begin
                        mode_done_d = 1'b1;
                    end else begin
                        pend_mode_d = req_mode;
                        to_cnt_d    = '0;
                        state_d     = ST_WAIT_VS;
                    end
                end
            end
            ST_WAIT_VS: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // Timing only ever changes here, while the generator is being put into reset.
                if (vs_rise || to_cnt_q == TO_LAST) begin
                    timeout_err_d = ~vs_rise;
                    gen_rstn_d    = 1'b0;
                    timing_d      = rom_timing;
                    frame_cnt_d   = '0;
                    hold_cnt_d    = '0;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d  = '0;
                    gen_rstn_d  = 1'b1;
                    cur_mode_d  = pend_mode_q;
                    mode_done_d = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_INIT;
            hold_cnt_q    <= '0;
            to_cnt_q      <= '0;
            pend_mode_q   <= DEFAULT_MODE;
            cur_mode_q    <= DEFAULT_MODE;
            timing_q      <= RESET_TIMING;
            gen_rstn_q    <= 1'b0;
            mode_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_cnt_q   <= '0;
            vs_dly_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            to_cnt_q      <= to_cnt_d;
            pend_mode_q   <= pend_mode_d;
            cur_mode_q    <= cur_mode_d;
            timing_q      <= timing_d;
            gen_rstn_q    <= gen_rstn_d;
            mode_done_q   <= mode_done_d;
            timeout_err_q <= timeout_err_d;
            frame_cnt_q   <= frame_cnt_d;
            vs_dly_q      <= vs_dly_d;
        end
    end

    assign req_ready   = (state_q == ST_RUN);
    assign busy        = (state_q == ST_WAIT_VS) || (state_q == ST_HOLD);
    assign gen_rstn    = gen_rstn_q;
    assign cur_mode    = cur_mode_q;
    assign mode_done   = mode_done_q;
    assign timeout_err = timeout_err_q;
    assign frame_cnt   = frame_cnt_q;

    assign h_total = X_BITS'(timing_q.h_total);
    assign h_fp    = X_BITS'(timing_q.h_fp);
    assign h_bp    = X_BITS'(timing_q.h_bp);
    assign h_sync  = X_BITS'(timing_q.h_sync);
    assign h_act   = X_BITS'(timing_q.h_act);
    assign v_total = Y_BITS'(timing_q.v_total);
    assign v_fp    = Y_BITS'(timing_q.v_fp);
    assign v_bp    = Y_BITS'(timing_q.v_bp);
    assign v_sync  = Y_BITS'(timing_q.v_sync);
    assign v_act   = Y_BITS'(timing_q.v_act);

endmodule
